// File: rtl/nibble_serial_adder_seq.sv
// rtl/nibble_serial_adder_seq.sv - nibble-serial wide adder driving an external combinational 4-bit adder
module nibble_serial_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    output logic [3:0]           adder_a,
    output logic [3:0]           adder_b,
    input  logic [3:0]           adder_result,
    input  logic                 adder_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_carry
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    // Upper nibbles still waiting to be presented to the adder; shifted down each step
    logic [W-5:0]  a_rest;
    logic [W-5:0]  b_rest;
    logic [IW-1:0] idx;
    logic          cin;
    logic [4:0]    nib_sum;
    logic          next_cin;

    // Fold the ripple carry into the external adder's result; both carries are never set together
    always_comb begin
        nib_sum  = {1'b0, adder_result} + {4'b0000, cin};
        next_cin = adder_carry | nib_sum[4];
    end

    // Control FSM with registered handshake and adder-operand outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            adder_a   <= 4'h0;
            adder_b   <= 4'h0;
            a_rest    <= '0;
            b_rest    <= '0;
            idx       <= '0;
            cin       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        adder_a  <= in_a[3:0];
                        adder_b  <= in_b[3:0];
                        a_rest   <= in_a[W-1:4];
                        b_rest   <= in_b[W-1:4];
                        idx      <= '0;
                        cin      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    out_sum[4*idx +: 4] <= nib_sum[3:0];
                    cin                 <= next_cin;
                    if (idx == LAST) begin
                        out_carry <= next_cin;
                        adder_a   <= 4'h0;
                        adder_b   <= 4'h0;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        adder_a <= a_rest[3:0];
                        adder_b <= b_rest[3:0];
                        a_rest  <= a_rest >> 4;
                        b_rest  <= b_rest >> 4;
                        idx     <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
